perf_access_ctrl: RTL and testbench

PERF_ACCESS_CTRL -- requirements
Module: perf_access_ctrl

---
 rtl/perf_access_ctrl.sv | 113 +++++++++++
 tb/tb_perf_access_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/perf_access_ctrl.sv
// rtl/perf_access_ctrl.sv - profile login controller with retry counting and timed lockout
module perf_access_ctrl #(
    parameter int                    PW          = 3,
    parameter logic [(1<<PW)-1:0]    VALID_MASK  = 8'h6A,
    parameter int                    MAX_TRIES   = 3,
    parameter int                    LOCK_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] perf,
    input  logic          confirm,
    input  logic          logout,
    output logic          valid_out,
    output logic          active,
    output logic [PW-1:0] perf_act,
    output logic          err,
    output logic          locked,
    output logic [3:0]    tries
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [LCW-1:0] lock_cnt;
    logic [3:0]     tries_inc;
    logic           attempt_ok;
    logic           attempt_bad;
    logic           lock_done;
    logic           hit_limit;

    assign valid_out   = VALID_MASK[perf];
    assign attempt_ok  = (state == IDLE) && confirm && valid_out;
    assign attempt_bad = (state == IDLE) && confirm && !valid_out;
    assign tries_inc   = tries + 4'd1;
    assign hit_limit   = (tries_inc == 4'(MAX_TRIES));
    assign lock_done   = (lock_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (attempt_ok) begin
                    state_nxt = ACTIVE;
                end else if (attempt_bad && hit_limit) begin
                    state_nxt = LOCKED;
                end
            end
            ACTIVE: begin
                if (logout) begin
                    state_nxt = IDLE;
                end
            end
            LOCKED: begin
                if (lock_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        active = (state == ACTIVE);
        locked = (state == LOCKED);
    end

    // Session data, retry count and lockout timer; confirm only counts in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_act <= '0;
            err      <= 1'b0;
            tries    <= 4'd0;
            lock_cnt <= '0;
        end else begin
            err <= attempt_bad;
            if (attempt_ok) begin
                perf_act <= perf;
                tries    <= 4'd0;
            end else if (attempt_bad) begin
                tries <= tries_inc;
                if (hit_limit) begin
                    lock_cnt <= LCW'(LOCK_CYCLES - 1);
                end
            end
            if (state == ACTIVE && logout) begin
                perf_act <= '0;
            end
            if (state == LOCKED) begin
                if (lock_done) begin
                    tries <= 4'd0;
                end else begin
                    lock_cnt <= lock_cnt - LCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_access_ctrl.sv
// tb/tb_perf_access_ctrl.sv - randomized and directed bench with behavioural login model
module tb_perf_access_ctrl;

    localparam int PW = 3;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_CYCLES = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] perf = '0;
    logic          confirm = 1'b0;
    logic          logout = 1'b0;
    logic          valid_out;
    logic          active;
    logic [PW-1:0] perf_act;
    logic          err;
    logic          locked;
    logic [3:0]    tries;

    perf_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .perf      (perf),
        .confirm   (confirm),
        .logout    (logout),
        .valid_out (valid_out),
        .active    (active),
        .perf_act  (perf_act),
        .err       (err),
        .locked    (locked),
        .tries     (tries)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural model: session flag, lockout cycles remaining, attempt count.
    bit m_session;
    bit m_locked;
    bit m_err;
    int m_perf_act;
    int m_tries;
    int m_left;

    function automatic bit is_valid(input int p);
        return (p == 1) || (p == 3) || (p == 5) || (p == 6);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_session = 0; m_locked = 0; m_err = 0;
        m_perf_act = 0; m_tries = 0; m_left = 0;
    endtask

    task automatic model_edge(input bit c, input bit l, input int p);
        m_err = 0;
        if (m_locked) begin
            m_left--;
            if (m_left == 0) begin
                m_locked = 0;
                m_tries = 0;
            end
        end else if (m_session) begin
            if (l) begin
                m_session = 0;
                m_perf_act = 0;
            end
        end else if (c) begin
            if (is_valid(p)) begin
                m_session = 1;
                m_perf_act = p;
                m_tries = 0;
            end else begin
                m_tries++;
                m_err = 1;
                if (m_tries == MAX_TRIES) begin
                    m_locked = 1;
                    m_left = LOCK_CYCLES;
                end
            end
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_active"}, 32'(active), 32'(m_session));
        check({tag, "_locked"}, 32'(locked), 32'(m_locked));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_perf_act"}, 32'(perf_act), 32'(m_perf_act));
        check({tag, "_tries"}, 32'(tries), 32'(m_tries));
    endtask

    task automatic step(input string tag, input bit c, input bit l, input int p);
        confirm = c;
        logout = l;
        perf = PW'(p);
        #1;
        check({tag, "_valid_out"}, 32'(valid_out), 32'(is_valid(p)));
        @(posedge clk);
        model_edge(c, l, p);
        #1;
        check_outs(tag);
    endtask

    initial begin
        model_reset();
        // Valid sweep while held in reset.
        for (int p = 0; p < 8; p++) begin
            perf = PW'(p);
            #1;
            check("sweep_valid_out", 32'(valid_out), 32'(is_valid(p)));
        end
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Login on 101, perf changes ignored, logout clears.
        step("login", 1, 0, 5);
        check("login_active", 32'(active), 32'd1);
        check("login_perf_act", 32'(perf_act), 32'd5);
        step("hold", 0, 0, 0);
        check("hold_perf_act", 32'(perf_act), 32'd5);
        step("hold2", 1, 0, 7);
        step("logout", 0, 1, 0);
        check("logout_active", 32'(active), 32'd0);
        step("idle", 0, 0, 0);

        // Three invalid confirms separated by idle cycles lead to lockout.
        for (int i = 0; i < 3; i++) begin
            step("bad", 1, 0, 7);
            check("bad_tries", 32'(tries), 32'(i + 1));
            check("bad_err", 32'(err), 32'd1);
            if (i < 2) step("gap", 0, 0, 7);
        end
        check("lock_rise", 32'(locked), 32'd1);
        for (int i = 0; i < LOCK_CYCLES + 2; i++) begin
            step("lockout", (i == 3), (i == 4), 1);
        end
        check("lock_end_tries", 32'(tries), 32'd0);
        check("lock_end_locked", 32'(locked), 32'd0);

        // Successful login clears tries.
        step("b1", 1, 0, 0);
        step("b2", 1, 0, 2);
        step("good", 1, 0, 3);
        check("good_tries", 32'(tries), 32'd0);
        step("out", 0, 1, 3);
        step("bad_again", 1, 0, 7);
        check("bad_again_tries", 32'(tries), 32'd1);
        step("gap3", 0, 0, 0);

        // Reset mid-cycle during lockout.
        step("h1", 1, 0, 7);
        step("h2", 1, 0, 7);
        check("pre_reset_tries", 32'(tries), 32'd3);
        check("pre_reset_locked", 32'(locked), 32'd1);
        confirm = 0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 1, 0, 1);
        check("post_reset_active", 32'(active), 32'd1);
        step("out2", 0, 1, 0);

        // confirm and logout together.
        step("both_idle", 1, 1, 6);
        check("both_idle_active", 32'(active), 32'd1);
        step("both_active", 1, 1, 6);
        check("both_active_idle", 32'(active), 32'd0);
        step("rest", 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step("rand", ($urandom % 3) == 0, ($urandom % 4) == 0, int'($urandom % 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
